// File: rtl/instr_fetch.sv
// instr_fetch: fetch front end with program counter, in-order fetch queue,
// valid/ready hand-off to decode and redirect (branch/jump) handling.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module instr_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush
`endif
);

    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

    logic [31:0]      r_pc;
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_qPc    [QUEUE_DEPTH];
    logic [31:0]      r_qInstr [QUEUE_DEPTH];

    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic [31:0] w_redirTarget;
    logic [31:0] w_headPc;
    logic [31:0] w_headInstr;

    // Handshake and push/pop decisions; the low two target bits are dropped
    // so every fetch address stays word aligned.
    always_comb begin
        w_full        = (r_count == DEPTH_C);
        out_valid     = (r_count != '0);
        w_pop         = out_valid & out_ready;
        w_push        = !redirect_valid & (!w_full | w_pop);
        w_redirTarget = redirect_pc & 32'hFFFF_FFFC;
        w_headPc      = r_qPc[r_rdPtr];
        w_headInstr   = r_qInstr[r_rdPtr];
    end

    // Program counter: reset, then redirect, then advance on every push.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= w_redirTarget;
        end else if (w_push) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    // Queue bookkeeping: a redirect flushes everything, including the
    // effect of a pop that decode still sees in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || redirect_valid) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage: capture the current pc with its instruction word.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_qPc[r_wrPtr]    <= r_pc;
            r_qInstr[r_wrPtr] <= imem_data;
        end
    end

    // Outputs come only from queue registers and read zero when empty.
    always_comb begin
        imem_addr    = r_pc;
        out_instr    = 32'd0;
        out_pc       = 32'd0;
        out_pc_plus4 = 32'd0;
        if (out_valid) begin
            out_instr    = w_headInstr;
            out_pc       = w_headPc;
            out_pc_plus4 = w_headPc + 32'd4;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perfFetched;
    logic [31:0] r_perfStall;
    logic [31:0] r_perfFlush;

    // Free-running wrap-around event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perfFetched <= 32'd0;
            r_perfStall   <= 32'd0;
            r_perfFlush   <= 32'd0;
        end else begin
            if (w_push) begin
                r_perfFetched <= r_perfFetched + 32'd1;
            end
            if (w_full && !w_pop) begin
                r_perfStall <= r_perfStall + 32'd1;
            end
            if (redirect_valid) begin
                r_perfFlush <= r_perfFlush + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perfFetched;
    assign perf_stall   = r_perfStall;
    assign perf_flush   = r_perfFlush;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed test of instr_fetch with a scoreboard of
// expected fetch addresses, compared whenever decode accepts an entry.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC_C = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
    logic [31:0] perf_flush;
`endif

    int totalChecks = 0;
    int passCount   = 0;
    logic [31:0] sbPc [$];

    instr_fetch #(
        .RESET_PC(RESET_PC_C),
        .QUEUE_DEPTH(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .imem_addr(imem_addr),
        .imem_data(imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_pc(out_pc),
        .out_pc_plus4(out_pc_plus4)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_stall(perf_stall),
        .perf_flush(perf_flush)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory contents, combinational read.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        if (addr == 32'h0000_0000)      return 32'h8C01_0000;
        else if (addr == 32'h0000_0004) return 32'h8C02_0004;
        else if (addr == 32'h0000_001C) return 32'h0800_0000;
        else                            return addr ^ 32'h5A5A_0000;
    endfunction

    assign imem_data = memWord(imem_addr);

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalChecks++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic pushStream(input logic [31:0] start);
        for (int i = 0; i < 8; i++) begin
            sbPc.push_back(start + 32'(4 * i));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rdy, input logic rv, input logic [31:0] rpc);
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    // Compare the entry decode is accepting this cycle against the scoreboard.
    task automatic checkOutput();
        logic [31:0] e;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sbPc.size() == 0) begin
                totalChecks++;
                $error("[TB] FAIL sb_underflow: got pc %h expected no entry", out_pc);
            end else begin
                e = sbPc.pop_front();
                checkEq("sb_pc", out_pc, e);
                checkEq("sb_instr", out_instr, memWord(e));
                checkEq("sb_plus4", out_pc_plus4, e + 32'd4);
            end
        end
    endtask

    // One clock cycle of stimulus; a redirect replaces the expected stream.
    task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
        applyStimulus(rdy, rv, rpc);
        checkOutput();
        if (rv) begin
            sbPc.delete();
            pushStream(rpc & 32'hFFFF_FFFC);
        end
        tick();
    endtask

    task automatic resetDut(input logic rv, input logic [31:0] rpc);
        reset = 1'b1;
        applyStimulus(1'b0, rv, rpc);
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'd0);
        sbPc.delete();
        pushStream(RESET_PC_C);
    endtask

    initial begin
        #1;
        tick();

        // Reset state and basic fetch with decode always ready
        resetDut(1'b0, 32'd0);
        checkEq("rst_valid", {31'd0, out_valid}, 32'd0);
        checkEq("rst_instr", out_instr, 32'd0);
        checkEq("rst_pc", out_pc, 32'd0);
        checkEq("rst_plus4", out_pc_plus4, 32'd0);
        checkEq("rst_addr", imem_addr, RESET_PC_C);
        cycle(1'b1, 1'b0, 32'd0);
        checkEq("c2_valid", {31'd0, out_valid}, 32'd1);
        checkEq("c2_pc", out_pc, 32'h0000_0000);
        checkEq("c2_instr", out_instr, 32'h8C01_0000);
        cycle(1'b1, 1'b0, 32'd0);
        checkEq("c3_pc", out_pc, 32'h0000_0004);
        checkEq("c3_instr", out_instr, 32'h8C02_0004);
        checkEq("c3_plus4", out_pc_plus4, 32'h0000_0008);
        for (int i = 0; i < 3; i++) begin
            checkEq("tput_valid", {31'd0, out_valid}, 32'd1);
            cycle(1'b1, 1'b0, 32'd0);
        end

        // Backpressure: queue fills, pc stalls, then drains without gaps
        resetDut(1'b0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 32'd0);
        end
        checkEq("bp_addr", imem_addr, 32'h0000_0008);
        checkEq("bp_valid", {31'd0, out_valid}, 32'd1);
        checkEq("bp_head", out_pc, 32'h0000_0000);
        cycle(1'b0, 1'b0, 32'd0);
        checkEq("bp_addr_hold", imem_addr, 32'h0000_0008);
        for (int i = 0; i < 4; i++) begin
            checkEq("drain_valid", {31'd0, out_valid}, 32'd1);
            cycle(1'b1, 1'b0, 32'd0);
        end

        // Redirect after pc 0 and 4 were fetched
        resetDut(1'b0, 32'd0);
        cycle(1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b1, 32'h0000_001C);
        checkEq("rd_flush_valid", {31'd0, out_valid}, 32'd0);
        checkEq("rd_addr", imem_addr, 32'h0000_001C);
        cycle(1'b1, 1'b0, 32'd0);
        checkEq("rd_valid", {31'd0, out_valid}, 32'd1);
        checkEq("rd_pc", out_pc, 32'h0000_001C);
        checkEq("rd_instr", out_instr, 32'h0800_0000);
        cycle(1'b1, 1'b0, 32'd0);
        cycle(1'b1, 1'b1, 32'h0000_001E);
        checkEq("rd2_flush_valid", {31'd0, out_valid}, 32'd0);
        cycle(1'b1, 1'b0, 32'd0);
        checkEq("rd2_pc", out_pc, 32'h0000_001C);
        cycle(1'b1, 1'b0, 32'd0);

        // Redirect with full queue and a same-cycle pop
        resetDut(1'b0, 32'd0);
        cycle(1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 32'd0);
        checkEq("full_addr", imem_addr, 32'h0000_0008);
        cycle(1'b1, 1'b1, 32'h0000_0040);
        checkEq("fp_empty", {31'd0, out_valid}, 32'd0);
        checkEq("fp_addr", imem_addr, 32'h0000_0040);
        cycle(1'b1, 1'b0, 32'd0);
        checkEq("fp_pc", out_pc, 32'h0000_0040);

        // Address wrap at the top of memory
        cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
        checkEq("wr_empty", {31'd0, out_valid}, 32'd0);
        cycle(1'b1, 1'b0, 32'd0);
        checkEq("wr_pc", out_pc, 32'hFFFF_FFFC);
        checkEq("wr_plus4", out_pc_plus4, 32'h0000_0000);
        cycle(1'b1, 1'b0, 32'd0);
        checkEq("wr_next_pc", out_pc, 32'h0000_0000);
        cycle(1'b1, 1'b0, 32'd0);

        // Reset mid-stream with entries queued and a same-cycle redirect
        cycle(1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 32'd0);
        cycle(1'b0, 1'b0, 32'd0);
        checkEq("mr_pre_valid", {31'd0, out_valid}, 32'd1);
        resetDut(1'b1, 32'h0000_0080);
        checkEq("mr_valid", {31'd0, out_valid}, 32'd0);
        checkEq("mr_addr", imem_addr, RESET_PC_C);
`ifdef FETCH_PERF_EN
        checkEq("mr_perf_fetched", perf_fetched, 32'd0);
        checkEq("mr_perf_stall", perf_stall, 32'd0);
        checkEq("mr_perf_flush", perf_flush, 32'd0);
`endif
        cycle(1'b1, 1'b0, 32'd0);
        checkEq("mr_restart_valid", {31'd0, out_valid}, 32'd1);
        checkEq("mr_restart_pc", out_pc, RESET_PC_C);
        cycle(1'b1, 1'b0, 32'd0);
        cycle(1'b1, 1'b0, 32'd0);

        $display("%0d/%0d checks passed", passCount, totalChecks);
        $finish;
    end

endmodule
